// File: rtl/piso.sv
// Parallel-in serial-out converter: takes one packed word of depth_p elements
// and streams them out element 0 first over a width_p-bit ready/valid link.
module piso #(
   parameter int width_p = 8,
   parameter int depth_p = 128
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       valid_i,
   input  logic [width_p*depth_p-1:0] data_i,
   output logic                       ready_o,
   output logic                       valid_o,
   output logic [width_p-1:0]         data_o,
   output logic                       last_o,
   input  logic                       ready_i
);

   localparam int cnt_w_lp = $clog2(depth_p);
   localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(depth_p - 1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e                       state_r, state_n;
   logic [cnt_w_lp-1:0]          cnt_r, cnt_n;
   logic [width_p*depth_p-1:0]   shift_r;
   logic                         load;
   logic                         xfer;
   logic                         at_last;

   assign at_last = (cnt_r == cnt_last_lp);

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      load    = 1'b0;
      xfer    = 1'b0;
      case (state_r)
         IDLE: begin
            if (valid_i) begin
               load    = 1'b1;
               cnt_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (ready_i) begin
               xfer = 1'b1;
               if (at_last) begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt_r + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
      end
   end

   // Data path carries no reset; data_o is only meaningful while valid_o is high.
   always_ff @(posedge clk_i) begin
      if (load) begin
         shift_r <= data_i;
      end else if (xfer && !at_last) begin
         shift_r <= shift_r >> width_p;
      end
   end

   assign ready_o = (state_r == IDLE);
   assign valid_o = (state_r == SEND);
   assign last_o  = (state_r == SEND) && at_last;
   assign data_o  = shift_r[width_p-1:0];

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: 8x4 instance for stream/backpressure/reset/throttle
// scenarios and a 4x3 instance for the non-power-of-two depth.
module tb_piso;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;

   logic        valid_i4 = 1'b0;
   logic [31:0] data_i4 = '0;
   logic        ready_i4 = 1'b1;
   logic        ready_o4, valid_o4, last_o4;
   logic [7:0]  data_o4;

   logic        valid_i3 = 1'b0;
   logic [11:0] data_i3 = '0;
   logic        ready_i3 = 1'b1;
   logic        ready_o3, valid_o3, last_o3;
   logic [3:0]  data_o3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   piso #(.width_p(8), .depth_p(4)) dut4 (
      .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i4), .data_i(data_i4),
      .ready_o(ready_o4), .valid_o(valid_o4), .data_o(data_o4), .last_o(last_o4),
      .ready_i(ready_i4)
   );

   piso #(.width_p(4), .depth_p(3)) dut3 (
      .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i3), .data_i(data_i3),
      .ready_o(ready_o3), .valid_o(valid_o3), .data_o(data_o3), .last_o(last_o3),
      .ready_i(ready_i3)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         n_vec++;
         if ({ready_o4, valid_o4, last_o4} !== 3'b100) begin
            n_err++;
            $display("FAIL reset4[%0d] rdy/vld/last got %b want 100", c, {ready_o4, valid_o4, last_o4});
         end
         n_vec++;
         if ({ready_o3, valid_o3, last_o3} !== 3'b100) begin
            n_err++;
            $display("FAIL reset3[%0d] rdy/vld/last got %b want 100", c, {ready_o3, valid_o3, last_o3});
         end
         if (c == 0) begin
            @(negedge clk_i);
            reset_ni = 1'b1;
            tick();
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_d [4];
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
      valid_i4 = 1'b1;
      data_i4  = 32'h44332211;
      ready_i4 = 1'b1;
      n_vec++;
      if (ready_o4 !== 1'b1) begin
         n_err++;
         $display("FAIL basic_ready_before_load got %b want 1", ready_o4);
      end
      tick();
      valid_i4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({valid_o4, ready_o4, last_o4, data_o4} !== {1'b1, 1'b0, (i == 3), exp_d[i]}) begin
            n_err++;
            $display("FAIL basic[%0d] vld/rdy/last/data got %b/%b/%b/%h want 1/0/%b/%h",
                     i, valid_o4, ready_o4, last_o4, data_o4, (i == 3), exp_d[i]);
         end
         tick();
      end
      n_vec++;
      if ({valid_o4, ready_o4, last_o4} !== 3'b010) begin
         n_err++;
         $display("FAIL basic_end vld/rdy/last got %b want 010", {valid_o4, ready_o4, last_o4});
      end
   endtask

   task automatic test_backpressure();
      valid_i4 = 1'b1;
      data_i4  = 32'h44332211;
      ready_i4 = 1'b1;
      tick();
      valid_i4 = 1'b0;
      n_vec++;
      if ({valid_o4, data_o4} !== {1'b1, 8'h11}) begin
         n_err++;
         $display("FAIL bp_first vld/data got %b/%h want 1/11", valid_o4, data_o4);
      end
      tick();
      ready_i4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if ({valid_o4, last_o4, data_o4} !== {1'b1, 1'b0, 8'h22}) begin
            n_err++;
            $display("FAIL bp_hold[%0d] vld/last/data got %b/%b/%h want 1/0/22", i, valid_o4, last_o4, data_o4);
         end
      end
      ready_i4 = 1'b1;
      tick();
      n_vec++;
      if ({valid_o4, last_o4, data_o4} !== {1'b1, 1'b0, 8'h33}) begin
         n_err++;
         $display("FAIL bp_resume33 vld/last/data got %b/%b/%h want 1/0/33", valid_o4, last_o4, data_o4);
      end
      tick();
      n_vec++;
      if ({valid_o4, last_o4, data_o4} !== {1'b1, 1'b1, 8'h44}) begin
         n_err++;
         $display("FAIL bp_resume44 vld/last/data got %b/%b/%h want 1/1/44", valid_o4, last_o4, data_o4);
      end
      tick();
      n_vec++;
      if ({valid_o4, ready_o4} !== 2'b01) begin
         n_err++;
         $display("FAIL bp_end vld/rdy got %b want 01", {valid_o4, ready_o4});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d [8];
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      valid_i4 = 1'b1;
      data_i4  = 32'h44332211;
      ready_i4 = 1'b1;
      tick();
      data_i4 = 32'hDDCCBBAA;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({valid_o4, last_o4, data_o4} !== {1'b1, (i == 3), exp_d[i]}) begin
            n_err++;
            $display("FAIL b2b_w0[%0d] vld/last/data got %b/%b/%h want 1/%b/%h",
                     i, valid_o4, last_o4, data_o4, (i == 3), exp_d[i]);
         end
         tick();
      end
      n_vec++;
      if ({valid_o4, ready_o4} !== 2'b01) begin
         n_err++;
         $display("FAIL b2b_bubble vld/rdy got %b want 01", {valid_o4, ready_o4});
      end
      tick();
      valid_i4 = 1'b0;
      for (int i = 4; i < 8; i++) begin
         n_vec++;
         if ({valid_o4, last_o4, data_o4} !== {1'b1, (i == 7), exp_d[i]}) begin
            n_err++;
            $display("FAIL b2b_w1[%0d] vld/last/data got %b/%b/%h want 1/%b/%h",
                     i - 4, valid_o4, last_o4, data_o4, (i == 7), exp_d[i]);
         end
         tick();
      end
      n_vec++;
      if ({valid_o4, ready_o4} !== 2'b01) begin
         n_err++;
         $display("FAIL b2b_end vld/rdy got %b want 01", {valid_o4, ready_o4});
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_d [4];
      exp_d = '{8'h05, 8'h06, 8'h07, 8'h08};
      valid_i4 = 1'b1;
      data_i4  = 32'h44332211;
      ready_i4 = 1'b1;
      tick();
      valid_i4 = 1'b0;
      tick();
      tick();
      n_vec++;
      if (data_o4 !== 8'h33) begin
         n_err++;
         $display("FAIL rstmid_pre data got %h want 33", data_o4);
      end
      #2;
      reset_ni = 1'b0;
      #1;
      n_vec++;
      if ({valid_o4, ready_o4, last_o4} !== 3'b010) begin
         n_err++;
         $display("FAIL rstmid_async vld/rdy/last got %b want 010", {valid_o4, ready_o4, last_o4});
      end
      valid_i4 = 1'b1;
      data_i4  = 32'h08070605;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_vec++;
         if ({valid_o4, ready_o4} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_held[%0d] vld/rdy got %b want 01", c, {valid_o4, ready_o4});
         end
      end
      @(negedge clk_i);
      reset_ni = 1'b1;
      tick();
      valid_i4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({valid_o4, last_o4, data_o4} !== {1'b1, (i == 3), exp_d[i]}) begin
            n_err++;
            $display("FAIL rstmid_new[%0d] vld/last/data got %b/%b/%h want 1/%b/%h",
                     i, valid_o4, last_o4, data_o4, (i == 3), exp_d[i]);
         end
         tick();
      end
   endtask

   task automatic test_npow2();
      logic [3:0] exp_d [3];
      exp_d = '{4'hA, 4'hB, 4'hC};
      valid_i3 = 1'b1;
      data_i3  = 12'hCBA;
      ready_i3 = 1'b1;
      tick();
      valid_i3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({valid_o3, last_o3, data_o3} !== {1'b1, (i == 2), exp_d[i]}) begin
            n_err++;
            $display("FAIL npow2[%0d] vld/last/data got %b/%b/%h want 1/%b/%h",
                     i, valid_o3, last_o3, data_o3, (i == 2), exp_d[i]);
         end
         n_vec++;
         if (dut3.cnt_r !== 2'(i)) begin
            n_err++;
            $display("FAIL npow2_cnt[%0d] got %0d want %0d", i, dut3.cnt_r, i);
         end
         tick();
      end
      n_vec++;
      if ({valid_o3, ready_o3, dut3.cnt_r} !== 4'b0100) begin
         n_err++;
         $display("FAIL npow2_end vld/rdy/cnt got %b want 0100", {valid_o3, ready_o3, dut3.cnt_r});
      end
   endtask

   task automatic test_throttle();
      logic [7:0] sb [$];
      int words = 0;
      int elems = 0;
      int cyc = 0;
      logic [7:0] exp_b;
      valid_i4 = 1'b1;
      data_i4  = $urandom;
      while ((words < 50 || sb.size() != 0) && cyc < 5000) begin
         ready_i4 = ($urandom_range(0, 2) != 0);
         if (valid_o4 && ready_i4) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL thr_extra elem data got %h want none", data_o4);
            end else begin
               exp_b = sb.pop_front();
               if (data_o4 !== exp_b || last_o4 !== ((elems % 4) == 3)) begin
                  n_err++;
                  $display("FAIL thr_elem[%0d] data/last got %h/%b want %h/%b",
                           elems, data_o4, last_o4, exp_b, ((elems % 4) == 3));
               end
            end
            elems++;
         end
         if (valid_i4 && ready_o4) begin
            for (int k = 0; k < 4; k++) sb.push_back(data_i4[k*8 +: 8]);
            words++;
            tick();
            cyc++;
            if (words < 50) data_i4 = $urandom;
            else valid_i4 = 1'b0;
         end else begin
            tick();
            cyc++;
         end
      end
      valid_i4 = 1'b0;
      ready_i4 = 1'b1;
      n_vec++;
      if (elems !== 200 || sb.size() != 0) begin
         n_err++;
         $display("FAIL thr_total elems/left got %0d/%0d want 200/0 (cycles %0d)", elems, sb.size(), cyc);
      end
   endtask

   initial begin
      #3;
      test_reset();
      test_basic();
      tick();
      test_backpressure();
      tick();
      test_back_to_back();
      tick();
      test_reset_mid();
      test_npow2();
      tick();
      test_throttle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
